// File: rtl/if_stage_pkg.sv
// rtl/if_stage_pkg.sv - shared constants for the fetch stage and its IF/ID register
package if_stage_pkg;

    localparam int unsigned XLEN = 32;

    // addi x0,x0,0: the canonical bubble word
    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_STEP          = 32'd4;

    // Major opcodes, shared with decode
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

endpackage

// File: rtl/if_stage_id_reg.sv
// rtl/if_stage_id_reg.sv - IF/ID pipeline register with hold, flush and reset-to-bubble
//   clk, rst               : clock, synchronous active-high reset
//   hold                   : keep current contents
//   flush                  : replace instruction with a bubble, keep pc fields
//   d_pc/d_pc_plus4/d_instr/d_valid : next contents on a normal advance
//   q_pc/q_pc_plus4/q_instr/q_valid : registered contents
module if_id_reg
    import if_stage_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            hold,
    input  logic            flush,
    input  logic [XLEN-1:0] d_pc,
    input  logic [XLEN-1:0] d_pc_plus4,
    input  logic [XLEN-1:0] d_instr,
    input  logic            d_valid,
    output logic [XLEN-1:0] q_pc,
    output logic [XLEN-1:0] q_pc_plus4,
    output logic [XLEN-1:0] q_instr,
    output logic            q_valid
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q_pc       <= '0;
            q_pc_plus4 <= PC_STEP;
            q_instr    <= NOP_INSTR;
            q_valid    <= 1'b0;
        end else if (flush) begin
            // pc fields intentionally hold: a bubble carries no meaningful PC
            q_instr    <= NOP_INSTR;
            q_valid    <= 1'b0;
        end else if (!hold) begin
            q_pc       <= d_pc;
            q_pc_plus4 <= d_pc_plus4;
            q_instr    <= d_instr;
            q_valid    <= d_valid;
        end
    end

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch: PC, range check, error pulses, fetch counter
//   clk, rst                         : clock, synchronous active-high reset
//   stall                            : hold PC and IF/ID
//   redirect_valid, redirect_target  : EX-stage branch/jump redirect (overrides stall)
//   imem_addr, imem_rdata            : combinational instruction memory port
//   id_pc, id_pc_plus4, id_instr, id_valid : IF/ID register contents
//   misalign_err, oob_err            : one-cycle error pulses
//   fetch_count                      : valid instructions captured into IF/ID
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int unsigned IMEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    output logic [31:0] id_instr,
    output logic        id_valid,
    output logic        misalign_err,
    output logic        oob_err,
    output logic [31:0] fetch_count
);

    localparam logic [29:0] IMEM_LIMIT = 30'(IMEM_WORDS);

    logic [31:0] pc_q;
    logic [31:0] pc_plus4;
    logic        in_range;
    logic [31:0] fetch_word;

    assign imem_addr  = pc_q;
    assign pc_plus4   = pc_q + PC_STEP;
    assign in_range   = (pc_q[31:2] < IMEM_LIMIT);
    assign fetch_word = in_range ? imem_rdata : NOP_INSTR;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= RESET_PC;
            misalign_err <= 1'b0;
            oob_err      <= 1'b0;
            fetch_count  <= '0;
        end else if (redirect_valid) begin
            // low bits are dropped so fetch stays word-aligned; the fault is reported
            pc_q         <= redirect_target & ~32'h3;
            misalign_err <= |redirect_target[1:0];
            oob_err      <= 1'b0;
        end else if (stall) begin
            misalign_err <= 1'b0;
            oob_err      <= 1'b0;
        end else begin
            pc_q         <= pc_plus4;
            misalign_err <= 1'b0;
            oob_err      <= ~in_range;
            if (in_range) begin
                fetch_count <= fetch_count + 32'd1;
            end
        end
    end

    if_id_reg u_if_id_reg (
        .clk        (clk),
        .rst        (rst),
        .hold       (stall),
        .flush      (redirect_valid),
        .d_pc       (pc_q),
        .d_pc_plus4 (pc_plus4),
        .d_instr    (fetch_word),
        .d_valid    (in_range),
        .q_pc       (id_pc),
        .q_pc_plus4 (id_pc_plus4),
        .q_instr    (id_instr),
        .q_valid    (id_valid)
    );

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - randomized scoreboard bench for if_stage
module tb_if_stage;

    localparam int unsigned WORDS = 64;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] JUNK  = 32'hDEAD_BEEF;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] instr;
        logic        valid;
        logic        mis;
        logic        oob;
        logic [31:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = '0;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic [31:0] id_instr;
    logic        id_valid;
    logic        misalign_err;
    logic        oob_err;
    logic [31:0] fetch_count;

    logic [31:0] imem [WORDS];
    exp_t        sb_q [$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    bit          done = 1'b0;

    // Reference state: the architectural view of the stage
    longint unsigned m_pc, m_idpc, m_cnt;
    logic [31:0]     m_instr;
    bit              m_valid, m_mis, m_oob;

    always #5 clk = ~clk;

    assign imem_rdata = (imem_addr[31:2] < WORDS) ? imem[imem_addr[7:2]] : JUNK;

    if_stage #(.RESET_PC(32'h0), .IMEM_WORDS(WORDS)) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_addr       (imem_addr),
        .imem_rdata      (imem_rdata),
        .id_pc           (id_pc),
        .id_pc_plus4     (id_pc_plus4),
        .id_instr        (id_instr),
        .id_valid        (id_valid),
        .misalign_err    (misalign_err),
        .oob_err         (oob_err),
        .fetch_count     (fetch_count)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, got, exp);
        end
    endtask

    // Advance the reference by one clock edge using the stage's rules
    task automatic model_step(input bit r, input bit st, input bit rv, input logic [31:0] rt);
        longint unsigned word;
        if (r) begin
            m_pc = 0; m_idpc = 0; m_instr = NOP; m_valid = 0;
            m_mis = 0; m_oob = 0; m_cnt = 0;
        end else if (rv) begin
            m_pc    = rt - (rt % 4);
            m_instr = NOP;
            m_valid = 0;
            m_mis   = (rt % 4) != 0;
            m_oob   = 0;
        end else if (st) begin
            m_mis = 0;
            m_oob = 0;
        end else begin
            word   = m_pc / 4;
            m_idpc = m_pc;
            m_pc   = (m_pc + 4) % (64'd1 << 32);
            m_mis  = 0;
            if (word < WORDS) begin
                m_instr = imem[word];
                m_valid = 1;
                m_oob   = 0;
                m_cnt   = (m_cnt + 1) % (64'd1 << 32);
            end else begin
                m_instr = NOP;
                m_valid = 0;
                m_oob   = 1;
            end
        end
    endtask

    task automatic cycle(input bit r, input bit st, input bit rv, input logic [31:0] rt);
        exp_t e;
        @(negedge clk);
        rst = r; stall = st; redirect_valid = rv; redirect_target = rt;
        model_step(r, st, rv, rt);
        e.addr  = 32'(m_pc);
        e.pc    = 32'(m_idpc);
        e.pc4   = 32'(m_idpc + 4);
        e.instr = m_instr;
        e.valid = m_valid;
        e.mis   = m_mis;
        e.oob   = m_oob;
        e.cnt   = 32'(m_cnt);
        sb_q.push_back(e);
    endtask

    // Monitor: compares the DUT against the oldest expectation after each edge
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            cyc++;
            chk("imem_addr",    imem_addr,          e.addr);
            chk("id_pc",        id_pc,              e.pc);
            chk("id_pc_plus4",  id_pc_plus4,        e.pc4);
            chk("id_instr",     id_instr,           e.instr);
            chk("id_valid",     32'(id_valid),      32'(e.valid));
            chk("misalign_err", 32'(misalign_err),  32'(e.mis));
            chk("oob_err",      32'(oob_err),       32'(e.oob));
            chk("fetch_count",  fetch_count,        e.cnt);
        end
    end

    initial begin
        logic [31:0] t;
        int unsigned sel;
        for (int i = 0; i < WORDS; i++) imem[i] = $urandom;
        imem[0] = 32'h0010_0093;
        imem[1] = 32'h0010_8113;
        imem[2] = 32'h0011_01B3;

        // reset, then straight-line fetch of words 0..2
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        // id_pc=4 here: stall two cycles then resume
        cycle(0, 1, 0, 0);
        cycle(0, 1, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        // redirect overrides stall
        cycle(0, 1, 1, 32'h10);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        // misaligned redirect
        cycle(0, 0, 1, 32'h6);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        // run past the end of instruction memory, then recover
        cycle(0, 0, 1, 32'hF0);
        for (int i = 0; i < 7; i++) cycle(0, 0, 0, 0);
        cycle(0, 1, 0, 0);
        cycle(0, 0, 1, 32'h0);
        cycle(0, 0, 0, 0);
        // PC wraps from the top of the address space
        cycle(0, 0, 1, 32'hFFFF_FFFC);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        // reset wins over a simultaneous redirect
        cycle(0, 0, 0, 0);
        cycle(1, 1, 1, 32'h20);
        cycle(0, 0, 0, 0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            sel = $urandom_range(0, 3);
            case (sel)
                0: t = $urandom_range(0, WORDS - 1) * 4;
                1: t = $urandom_range(WORDS - 4, WORDS + 4) * 4;
                2: t = $urandom;
                default: t = $urandom_range(0, 4 * WORDS);
            endcase
            cycle(($urandom_range(0, 99) == 0),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 9) == 0),
                  t);
        end

        @(negedge clk);
        rst = 0; stall = 1; redirect_valid = 0;
        repeat (3) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
